eeprom_i2c_ctrl: RTL and testbench

- Bus master that sequences the 2 KB I2C serial EEPROM model (24C16 style, 8 pages of 256 bytes) over its two-wire scl/sda interface.
- Converts single-cycle byte-write and random-read requests from the host side into complete I2C transactions.
- Handles START, control byte, word address, data, ACK/NACK, repeated START and STOP.
- Sits between host logic and the EEPROM, and is the only master on the bus.

---
 rtl/eeprom_i2c_ctrl_if.sv | 22 ++
 rtl/eeprom_i2c_ctrl.sv | 178 +++++++++++++++++
 tb/tb_eeprom_i2c_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/eeprom_i2c_ctrl_if.sv
// Host-side request/response bundle for the I2C EEPROM controller.
// The controller sits on the slave modport; host logic drives the master modport.
interface eeprom_i2c_ctrl_if;
   logic        wr_req;
   logic        rd_req;
   logic [10:0] addr;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        busy;
   logic        done;
   logic        ack_err;

   modport master (
      output wr_req, rd_req, addr, wdata,
      input  rdata, busy, done, ack_err
   );

   modport slave (
      input  wr_req, rd_req, addr, wdata,
      output rdata, busy, done, ack_err
   );
endinterface

// File: rtl/eeprom_i2c_ctrl.sv
// Single-master I2C sequencer for a 24C16-style EEPROM: byte write and random read.
// Bus outputs are registered from the current state, so scl/sda trail the FSM by one clk.
module eeprom_i2c_ctrl #(
   parameter int         CLK_DIV = 4,
   parameter logic [3:0] DEV_ID  = 4'b1010
) (
   input  logic              clk,
   input  logic              rst_n,
   eeprom_i2c_ctrl_if.slave  host,
   output logic              scl,
   inout  wire               sda
);
   localparam int            DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

   typedef enum logic [3:0] {
      IDLE, START, CTRL_W, ACK1, WADDR, ACK2, WDATA, ACK3,
      RSTART, CTRL_R, RDATA, NACK, STOP, DONE
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] div_q;
   logic [1:0]    qtr_q;
   logic [2:0]    bit_q;
   logic [10:0]   addr_q;
   logic [7:0]    wdata_q, tx_q, tx_d, rx_q, rdata_q;
   logic          rd_q, busy_q, done_q, ack_err_q;
   logic          scl_q, scl_d, oe_q, oe_d;
   logic          sda_m_q, sda_s_q;
   logic          tick, mid, byte_st, last_bit;

   assign tick    = (div_q == DIV_MAX);
   assign mid     = qtr_q[1] ^ qtr_q[0];
   assign byte_st = (state_q == CTRL_W) || (state_q == WADDR) || (state_q == WDATA) ||
                    (state_q == CTRL_R) || (state_q == RDATA);
   assign last_bit = !byte_st || (bit_q == 3'd7);

   // Bus levels for the current quarter; oe means "pull sda low".
   always_comb begin
      scl_d = 1'b1;
      oe_d  = 1'b0;
      case (state_q)
         START, RSTART: begin
            scl_d = mid;
            oe_d  = qtr_q[1];
         end
         CTRL_W, WADDR, WDATA, CTRL_R: begin
            scl_d = mid;
            oe_d  = ~tx_q[7];
         end
         ACK1, ACK2, ACK3, RDATA, NACK: begin
            scl_d = mid;
            oe_d  = 1'b0;
         end
         STOP: begin
            scl_d = (qtr_q != 2'd0);
            oe_d  = ~qtr_q[1];
         end
         default: begin
            scl_d = 1'b1;
            oe_d  = 1'b0;
         end
      endcase
   end

   // Successor state and shift-register contents at the end of a bit.
   always_comb begin
      state_d = state_q;
      tx_d    = {tx_q[6:0], 1'b0};
      case (state_q)
         START: begin
            state_d = CTRL_W;
            tx_d    = {DEV_ID, addr_q[10:8], 1'b0};
         end
         CTRL_W: state_d = ACK1;
         ACK1: begin
            if (ack_err_q) state_d = STOP;
            else begin
               state_d = WADDR;
               tx_d    = addr_q[7:0];
            end
         end
         WADDR: state_d = ACK2;
         ACK2: begin
            if (ack_err_q)  state_d = STOP;
            else if (rd_q)  state_d = RSTART;
            else begin
               state_d = WDATA;
               tx_d    = wdata_q;
            end
         end
         WDATA: state_d = ACK3;
         RSTART: begin
            state_d = CTRL_R;
            tx_d    = {DEV_ID, addr_q[10:8], 1'b1};
         end
         CTRL_R: state_d = ACK3;
         ACK3:   state_d = (!ack_err_q && rd_q) ? RDATA : STOP;
         RDATA:  state_d = NACK;
         NACK:   state_d = STOP;
         STOP:   state_d = DONE;
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         div_q     <= '0;
         qtr_q     <= '0;
         bit_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         rdata_q   <= '0;
         rd_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
         scl_q     <= 1'b1;
         oe_q      <= 1'b0;
         sda_m_q   <= 1'b1;
         sda_s_q   <= 1'b1;
      end else begin
         sda_m_q <= sda;
         sda_s_q <= sda_m_q;
         scl_q   <= scl_d;
         oe_q    <= oe_d;
         done_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (host.wr_req || host.rd_req) begin
                  addr_q    <= host.addr;
                  wdata_q   <= host.wdata;
                  rd_q      <= ~host.wr_req;
                  ack_err_q <= 1'b0;
                  busy_q    <= 1'b1;
                  div_q     <= '0;
                  qtr_q     <= '0;
                  bit_q     <= '0;
                  state_q   <= START;
               end
            end
            DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               if (rd_q && !ack_err_q) rdata_q <= rx_q;
               state_q <= IDLE;
            end
            default: begin
               div_q <= tick ? '0 : div_q + 1'b1;
               if (tick) begin
                  qtr_q <= qtr_q + 2'd1;
                  // Sample at the start of Q2, mid-way through scl high.
                  if (qtr_q == 2'd1) begin
                     if (((state_q == ACK1) || (state_q == ACK2) || (state_q == ACK3)) && sda_s_q)
                        ack_err_q <= 1'b1;
                     if (state_q == RDATA) rx_q <= {rx_q[6:0], sda_s_q};
                  end
                  if (qtr_q == 2'd3) begin
                     tx_q  <= tx_d;
                     bit_q <= last_bit ? 3'd0 : bit_q + 3'd1;
                     if (last_bit) state_q <= state_d;
                  end
               end
            end
         endcase
      end
   end

   assign host.rdata   = rdata_q;
   assign host.busy    = busy_q;
   assign host.done    = done_q;
   assign host.ack_err = ack_err_q;
   assign scl          = scl_q;
   assign sda          = oe_q ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_eeprom_i2c_ctrl.sv
// Bench for eeprom_i2c_ctrl: behavioural 24C16 slave, bus-byte and done scoreboards.
module tb_eeprom_i2c_ctrl;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic scl;
   wire  sda;
   pullup pu_sda (sda);

   always #5 clk = ~clk;

   eeprom_i2c_ctrl_if hif ();

   eeprom_i2c_ctrl #(.CLK_DIV(4), .DEV_ID(4'b1010)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .host  (hif),
      .scl   (scl),
      .sda   (sda)
   );

   typedef struct {
      logic [7:0] rdata;
      logic       err;
      int         lat;
      int         t_req;
   } exp_t;

   exp_t       scb[$];
   logic [7:0] exp_bus[$];
   int         n_chk = 0, n_fail = 0, n_done = 0, n_stop = 0, cyc = 0;
   logic       slave_en = 1'b1, bus_chk_en = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   // ---------------- behavioural EEPROM slave ----------------
   logic [7:0]  mem [0:2047];
   logic        s_low = 1'b0;
   logic        pscl = 1'b1, psda = 1'b1, cs, ds, s_act = 1'b0;
   int          s_bit = 0, s_ph = 0;
   logic [7:0]  s_sh = '0;
   logic [10:0] s_ptr = '0;

   assign sda = s_low ? 1'b0 : 1'bz;

   initial for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

   task automatic got_byte(input logic [7:0] b);
      if (bus_chk_en) begin
         if (exp_bus.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL bus_byte: got %0h with no byte pending", b);
         end else check("bus_byte", b, exp_bus.pop_front());
      end
   endtask

   always @(negedge clk) begin
      cs = scl;
      ds = (sda === 1'b0) ? 1'b0 : 1'b1;
      if (!rst_n) begin
         s_act = 1'b0;
         s_low = 1'b0;
         s_bit = 0;
      end else begin
         if (cs && pscl && !psda && ds) n_stop++;
         if (!slave_en) begin
            s_act = 1'b0;
            s_low = 1'b0;
         end else if (cs && pscl && psda && !ds) begin
            s_act = 1'b1; s_bit = 0; s_ph = 0; s_low = 1'b0;
         end else if (cs && pscl && !psda && ds) begin
            s_act = 1'b0; s_low = 1'b0;
         end else if (s_act && cs && !pscl) begin
            if (s_bit < 8) begin
               if (s_ph != 3) s_sh = {s_sh[6:0], ds};
            end else if (s_ph == 3 && ds) s_act = 1'b0;
            s_bit++;
         end else if (s_act && !cs && pscl) begin
            if (s_bit == 8) begin
               if (s_ph == 3) s_low = 1'b0;
               else begin
                  got_byte(s_sh);
                  case (s_ph)
                     0: begin s_ptr[10:8] = s_sh[3:1]; s_ph = s_sh[0] ? 3 : 1; end
                     1: begin s_ptr[7:0] = s_sh; s_ph = 2; end
                     default: begin mem[s_ptr] = s_sh; s_ptr[7:0] = s_ptr[7:0] + 8'd1; end
                  endcase
                  s_low = 1'b1;
               end
            end else if (s_bit == 9) begin
               s_bit = 0;
               s_low = 1'b0;
               if (s_ph == 3) begin
                  s_sh  = mem[s_ptr];
                  s_low = ~s_sh[7];
               end
            end else if (s_ph == 3 && s_bit > 0) begin
               s_sh  = {s_sh[6:0], 1'b0};
               s_low = ~s_sh[7];
            end
         end
      end
      pscl = cs;
      psda = ds;
   end

   // ---------------- done monitor ----------------
   exp_t mon_e;
   always @(negedge clk) begin
      if (rst_n && hif.done === 1'b1) begin
         n_done++;
         if (scb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: done pulse with no pending request");
         end else begin
            mon_e = scb.pop_front();
            check("latency", 32'(cyc - mon_e.t_req), 32'(mon_e.lat));
            check("ack_err_at_done", {31'd0, hif.ack_err}, {31'd0, mon_e.err});
            check("rdata_at_done", {24'd0, hif.rdata}, {24'd0, mon_e.rdata});
            check("busy_at_done", {31'd0, hif.busy}, 32'd0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic push_bus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      exp_bus.push_back(b0);
      exp_bus.push_back(b1);
      exp_bus.push_back(b2);
   endtask

   task automatic issue(input logic w, input logic r, input logic [10:0] a, input logic [7:0] d,
                        input logic push, input logic [7:0] erd, input logic eerr, input int elat);
      exp_t e;
      @(negedge clk);
      hif.wr_req = w; hif.rd_req = r; hif.addr = a; hif.wdata = d;
      @(posedge clk);
      #1;
      hif.wr_req = 1'b0;
      hif.rd_req = 1'b0;
      check("busy_after_req", {31'd0, hif.busy}, 32'd1);
      check("ack_err_cleared", {31'd0, hif.ack_err}, 32'd0);
      if (push) begin
         e.rdata = erd; e.err = eerr; e.lat = elat; e.t_req = cyc;
         scb.push_back(e);
      end
   endtask

   task automatic wait_done(input int n0);
      int k;
      k = 0;
      while (n_done == n0 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check("done_seen", {31'd0, n_done != n0}, 32'd1);
   endtask

   int n0, s0;

   initial begin
      hif.wr_req = 1'b0; hif.rd_req = 1'b0; hif.addr = '0; hif.wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_scl", {31'd0, scl}, 32'd1);
      check("rst_sda", {31'd0, sda === 1'b1}, 32'd1);
      check("rst_busy", {31'd0, hif.busy}, 32'd0);
      check("rst_done", {31'd0, hif.done}, 32'd0);
      check("rst_ack_err", {31'd0, hif.ack_err}, 32'd0);
      check("rst_rdata", {24'd0, hif.rdata}, 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Write then read 0x5A3
      n0 = n_done; s0 = n_stop;
      push_bus(8'hAA, 8'hA3, 8'h3C);
      issue(1'b1, 1'b0, 11'h5A3, 8'h3C, 1'b1, 8'h00, 1'b0, 465);
      wait_done(n0);
      check("mem_5a3", {24'd0, mem[11'h5A3]}, 32'h3C);
      check("stop_after_write", 32'(n_stop - s0), 32'd1);
      n0 = n_done;
      push_bus(8'hAA, 8'hA3, 8'hAB);
      issue(1'b0, 1'b1, 11'h5A3, 8'h00, 1'b1, 8'h3C, 1'b0, 625);
      wait_done(n0);

      // Boundary addresses
      n0 = n_done;
      push_bus(8'hA0, 8'h00, 8'h55);
      issue(1'b1, 1'b0, 11'h000, 8'h55, 1'b1, 8'h3C, 1'b0, 465);
      wait_done(n0);
      n0 = n_done;
      push_bus(8'hA0, 8'h00, 8'hA1);
      issue(1'b0, 1'b1, 11'h000, 8'h00, 1'b1, 8'h55, 1'b0, 625);
      wait_done(n0);
      n0 = n_done;
      push_bus(8'hAE, 8'hFF, 8'hAA);
      issue(1'b1, 1'b0, 11'h7FF, 8'hAA, 1'b1, 8'h55, 1'b0, 465);
      wait_done(n0);
      n0 = n_done;
      push_bus(8'hAE, 8'hFF, 8'hAF);
      issue(1'b0, 1'b1, 11'h7FF, 8'h00, 1'b1, 8'hAA, 1'b0, 625);
      wait_done(n0);

      // No slave on the bus: NACK on the control byte, STOP, done after 11 bits + 1 clk
      slave_en = 1'b0;
      n0 = n_done; s0 = n_stop;
      issue(1'b1, 1'b0, 11'h000, 8'h11, 1'b1, 8'hAA, 1'b1, 177);
      wait_done(n0);
      check("stop_after_nack", 32'(n_stop - s0), 32'd1);
      repeat (5) @(negedge clk);
      check("ack_err_held", {31'd0, hif.ack_err}, 32'd1);
      slave_en = 1'b1;

      // Simultaneous requests: write wins; a read while busy is ignored
      n0 = n_done;
      push_bus(8'hA2, 8'h23, 8'h77);
      issue(1'b1, 1'b1, 11'h123, 8'h77, 1'b1, 8'hAA, 1'b0, 465);
      repeat (50) @(negedge clk);
      hif.rd_req = 1'b1;
      @(negedge clk);
      hif.rd_req = 1'b0;
      wait_done(n0);
      repeat (700) @(negedge clk);
      check("single_done", 32'(n_done - n0), 32'd1);
      check("mem_123", {24'd0, mem[11'h123]}, 32'h77);

      // Reset in the middle of the word-address byte
      bus_chk_en = 1'b0;
      issue(1'b1, 1'b0, 11'h0AB, 8'h99, 1'b0, 8'h00, 1'b0, 0);
      repeat (200) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_rst_scl", {31'd0, scl}, 32'd1);
      check("mid_rst_sda", {31'd0, sda === 1'b1}, 32'd1);
      check("mid_rst_busy", {31'd0, hif.busy}, 32'd0);
      check("mid_rst_rdata", {24'd0, hif.rdata}, 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      bus_chk_en = 1'b1;
      n0 = n_done;
      push_bus(8'hAE, 8'hFF, 8'hAF);
      issue(1'b0, 1'b1, 11'h7FF, 8'h00, 1'b1, 8'hAA, 1'b0, 625);
      wait_done(n0);

      repeat (20) @(negedge clk);
      check("scb_drained", 32'(scb.size()), 32'd0);
      check("bus_drained", 32'(exp_bus.size()), 32'd0);
      check("total_done", 32'(n_done), 32'd9);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
